// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice.
// Holds the operation codes, the controller state encoding, the default
// operand width and the divide-by-zero quotient constant.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  // Quotient reported when the divisor is zero.
  localparam logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/result bus between the control unit and the ALU sequencer.
//   start, op, a_in, y_in : request from the control unit
//   busy, done, err       : handshake back to the control unit
//   zlo, zhi              : 2*WIDTH result (Z pair)
// master = control unit side, slave = sequencer side.
interface alu_sequencer_if #(
  parameter int WIDTH = alu_pkg::WIDTH
);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] y_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] zlo;
  logic [WIDTH-1:0] zhi;

  modport master (
    output start, op, a_in, y_in,
    input  busy, done, err, zlo, zhi
  );

  modport slave (
    input  start, op, a_in, y_in,
    output busy, done, err, zlo, zhi
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide datapath for the ALU sequencer.
//   clock, clear : clock and asynchronous active-high reset
//   load         : capture operands (y = multiplier/dividend, a = multiplicand/divisor)
//   is_div       : sampled with load, selects restoring division over Booth multiply
//   step         : perform one iteration
//   fix          : select the sign-corrected division result on hi/lo
//   hi, lo       : with fix=0, the product after the current step;
//                  with fix=1, remainder/quotient with signs applied
//   last_iter    : the current step is the final (WIDTH-th) iteration
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             is_div,
  input  logic             step,
  input  logic             fix,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last_iter
);

  logic             mode_div;
  logic [CNT_W-1:0] cnt;

  // Booth state. The high half carries one guard bit so that subtracting
  // a most-negative multiplicand cannot overflow before the shift.
  logic [WIDTH:0]   ph;
  logic [WIDTH-1:0] pl;
  logic             qm;
  logic [WIDTH-1:0] mcand;

  // Restoring division state on operand magnitudes.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sy;
  logic             sa;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   ph_n;
  logic [WIDTH-1:0] pl_n;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH-1:0] a_mag;

  always_comb begin
    sum = ph;
    case ({pl[0], qm})
      2'b01:   sum = ph + {mcand[WIDTH-1], mcand};
      2'b10:   sum = ph - {mcand[WIDTH-1], mcand};
      default: sum = ph;
    endcase
    ph_n = {sum[WIDTH], sum[WIDTH:1]};
    pl_n = {sum[0], pl[WIDTH-1:1]};

    trial = {rem, quo[WIDTH-1]};
    ge    = (trial >= {1'b0, dvs});
    rem_n = ge ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ge};

    q_s = (sy ^ sa) ? -quo : quo;
    r_s = sy ? -rem : rem;

    hi = fix ? r_s : ph_n[WIDTH-1:0];
    lo = fix ? q_s : pl_n;

    y_mag = y[WIDTH-1] ? -y : y;
    a_mag = a[WIDTH-1] ? -a : a;
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      mode_div <= 1'b0;
      cnt      <= '0;
      ph       <= '0;
      pl       <= '0;
      qm       <= 1'b0;
      mcand    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sy       <= 1'b0;
      sa       <= 1'b0;
    end else if (load) begin
      mode_div <= is_div;
      cnt      <= '0;
      ph       <= '0;
      pl       <= y;
      qm       <= 1'b0;
      mcand    <= a;
      rem      <= '0;
      quo      <= y_mag;
      dvs      <= a_mag;
      sy       <= y[WIDTH-1];
      sa       <= a[WIDTH-1];
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (mode_div) begin
        rem <= rem_n;
        quo <= quo_n;
      end else begin
        ph <= ph_n;
        pl <= pl_n;
        qm <= pl[0];
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller.
//   clock : system clock, rising edge
//   clear : asynchronous active-high reset
//   bus   : slave side of alu_sequencer_if (start/op/a_in/y_in in,
//           busy/done/err/zlo/zhi out)
// One operation is accepted per start pulse in IDLE. Single-cycle ops
// finish in EXEC; multiply and non-zero divide run in alu_muldiv_iter.
// done pulses for one cycle in DONE with err valid alongside it.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input logic             clock,
  input logic             clear,
  alu_sequencer_if.slave  bus
);

  state_t           state;
  logic [4:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] y_r;

  logic             md_load;
  logic             md_is_div;
  logic             md_step;
  logic             md_fix;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic             md_last;

  logic [WIDTH-1:0] exec_lo;
  logic [WIDTH-1:0] exec_hi;
  logic             exec_err;
  logic             exec_sext;

  logic             accept;
  logic             a_nz;

  assign accept    = (state == S_IDLE) && bus.start;
  assign a_nz      = (bus.a_in != '0);
  assign md_is_div = (bus.op == OP_DIV);
  assign md_load   = accept && ((bus.op == OP_MUL) || (md_is_div && a_nz));
  assign md_step   = (state == S_MUL) || (state == S_DIV);
  assign md_fix    = (state == S_FIX);

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clock     (clock),
    .clear     (clear),
    .load      (md_load),
    .is_div    (md_is_div),
    .step      (md_step),
    .fix       (md_fix),
    .a         (bus.a_in),
    .y         (bus.y_in),
    .hi        (md_hi),
    .lo        (md_lo),
    .last_iter (md_last)
  );

  // Only divide-by-zero and illegal codes reach EXEC without a
  // single-cycle result; multiply never does, so it lands in default.
  always_comb begin
    exec_lo   = '0;
    exec_hi   = '0;
    exec_err  = 1'b0;
    exec_sext = 1'b1;
    case (op_r)
      OP_ADD: exec_lo = y_r + a_r;
      OP_SUB: exec_lo = y_r - a_r;
      OP_SHR: exec_lo = y_r >> 1;
      OP_SHL: exec_lo = y_r << 1;
      OP_ROR: exec_lo = {y_r[0], y_r[WIDTH-1:1]};
      OP_ROL: exec_lo = {y_r[WIDTH-2:0], y_r[WIDTH-1]};
      OP_AND: exec_lo = y_r & a_r;
      OP_OR:  exec_lo = y_r | a_r;
      OP_NEG: exec_lo = -a_r;
      OP_NOT: exec_lo = ~a_r;
      OP_DIV: begin
        exec_lo   = DIV0_LO;
        exec_hi   = y_r;
        exec_err  = 1'b1;
        exec_sext = 1'b0;
      end
      default: begin
        exec_err  = 1'b1;
        exec_sext = 1'b0;
      end
    endcase
    if (exec_sext) exec_hi = {WIDTH{exec_lo[WIDTH-1]}};
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= S_IDLE;
      op_r     <= '0;
      a_r      <= '0;
      y_r      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      bus.zlo  <= '0;
      bus.zhi  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_r     <= bus.op;
            a_r      <= bus.a_in;
            y_r      <= bus.y_in;
            bus.busy <= 1'b1;
            if (bus.op == OP_MUL)            state <= S_MUL;
            else if (md_is_div && a_nz)      state <= S_DIV;
            else                             state <= S_EXEC;
          end
        end
        S_EXEC: begin
          bus.zlo  <= exec_lo;
          bus.zhi  <= exec_hi;
          bus.err  <= exec_err;
          bus.done <= 1'b1;
          state    <= S_DONE;
        end
        S_MUL: begin
          // hi/lo already reflect the step taken on this edge.
          if (md_last) begin
            bus.zlo  <= md_lo;
            bus.zhi  <= md_hi;
            bus.err  <= 1'b0;
            bus.done <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DIV: begin
          if (md_last) state <= S_FIX;
        end
        S_FIX: begin
          bus.zlo  <= md_lo;
          bus.zhi  <= md_hi;
          bus.err  <= 1'b0;
          bus.done <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed ops push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clock;
  logic clear;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   n_done;
  int   n_issued;
  logic prev_done;

  typedef struct {
    string       nm;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        er;
    int          due;
  } exp_t;

  exp_t sb[$];

  alu_sequencer_if #(.WIDTH(32)) bus ();

  alu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input string what,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %h expected %h", nm, what, act, exp);
  endtask

  // Monitor: compares every done pulse against the scoreboard head.
  always @(negedge clock) begin
    exp_t e;
    if (prev_done) begin
      check("mon", "done_one_cycle", 64'(bus.done), 64'd0);
      check("mon", "busy_after_done", 64'(bus.busy), 64'd0);
    end
    prev_done = bus.done;
    if (bus.done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL mon.unexpected_done: got done=1 expected no pending op (zlo=%h)", bus.zlo);
      end else begin
        e = sb.pop_front();
        check(e.nm, "zlo", 64'(bus.zlo), 64'(e.lo));
        check(e.nm, "zhi", 64'(bus.zhi), 64'(e.hi));
        check(e.nm, "err", 64'(bus.err), 64'(e.er));
        check(e.nm, "latency", 64'(cyc), 64'(e.due));
        check(e.nm, "busy_with_done", 64'(bus.busy), 64'd1);
      end
    end
  end

  // Start one op; done is due lat edges after the accepting edge.
  task automatic issue(input string nm, input logic [4:0] op,
                       input logic [31:0] y, input logic [31:0] a,
                       input logic [31:0] lo, input logic [31:0] hi,
                       input logic er, input int lat);
    exp_t e;
    e.nm = nm; e.lo = lo; e.hi = hi; e.er = er; e.due = cyc + 1 + lat;
    sb.push_back(e);
    n_issued++;
    bus.start = 1'b1;
    bus.op    = op;
    bus.y_in  = y;
    bus.a_in  = a;
    @(negedge clock);
    // Scramble inputs after acceptance; the op in flight must not see them.
    bus.start = 1'b0;
    bus.op    = 5'($urandom);
    bus.y_in  = $urandom;
    bus.a_in  = $urandom;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (n_done < n_issued && t < 100) begin
      @(negedge clock); #1;
      t++;
    end
    check(nm, "done_seen", 64'(n_done >= n_issued), 64'd1);
    @(negedge clock); #1;
  endtask

  task automatic run(input string nm, input logic [4:0] op,
                     input logic [31:0] y, input logic [31:0] a,
                     input logic [31:0] lo, input logic [31:0] hi,
                     input logic er, input int lat);
    issue(nm, op, y, a, lo, hi, er, lat);
    wait_done(nm);
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0; n_done = 0; n_issued = 0;
    prev_done = 1'b0;
    clear = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.a_in = '0; bus.y_in = '0;
    #2 clear = 1'b1;
    #1;
    check("reset", "busy", 64'(bus.busy), 64'd0);
    check("reset", "done", 64'(bus.done), 64'd0);
    check("reset", "err",  64'(bus.err),  64'd0);
    check("reset", "z", {bus.zhi, bus.zlo}, 64'd0);
    #1 clear = 1'b0;
    @(negedge clock); #1;

    run("add",     OP_ADD, 32'd5,          32'd7,          32'h0000000C, 32'h00000000, 1'b0, 1);
    run("sub",     OP_SUB, 32'd0,          32'd1,          32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1);
    run("shr",     OP_SHR, 32'h80000001,   32'd0,          32'h40000000, 32'h00000000, 1'b0, 1);
    run("shl",     OP_SHL, 32'hC0000001,   32'd0,          32'h80000002, 32'hFFFFFFFF, 1'b0, 1);
    run("ror",     OP_ROR, 32'h00000003,   32'd0,          32'h80000001, 32'hFFFFFFFF, 1'b0, 1);
    run("and",     OP_AND, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000, 32'hFFFFFFFF, 1'b0, 1);
    run("or",      OP_OR,  32'h0F000000,   32'h00F00001,   32'h0FF00001, 32'h00000000, 1'b0, 1);
    run("neg1",    OP_NEG, 32'd0,          32'd1,          32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1);
    run("negmin",  OP_NEG, 32'd0,          32'h80000000,   32'h80000000, 32'hFFFFFFFF, 1'b0, 1);
    run("not",     OP_NOT, 32'd0,          32'h7FFFFFFF,   32'h80000000, 32'hFFFFFFFF, 1'b0, 1);
    run("illegal", 5'b11111, 32'h1234,     32'h5678,       32'h00000000, 32'h00000000, 1'b1, 1);
    run("mul_n3x7",   OP_MUL, 32'hFFFFFFFD, 32'd7,          32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 32);
    run("mul_minsq",  OP_MUL, 32'h80000000, 32'h80000000,   32'h00000000, 32'h40000000, 1'b0, 32);
    run("mul_pos",    OP_MUL, 32'h12345678, 32'h00000010,   32'h23456780, 32'h00000001, 1'b0, 32);
    run("div_n7d2",   OP_DIV, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    run("div_by0",    OP_DIV, 32'd100,      32'd0,          32'hFFFFFFFF, 32'h00000064, 1'b1, 1);
    run("div_minm1",  OP_DIV, 32'h80000000, 32'hFFFFFFFF,   32'h80000000, 32'h00000000, 1'b0, 33);

    // Clear during a multiply: immediate reset values, no done.
    bus.start = 1'b1; bus.op = OP_MUL; bus.y_in = 32'd9; bus.a_in = 32'd9;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    #1 clear = 1'b1;
    #1;
    check("clear", "busy", 64'(bus.busy), 64'd0);
    check("clear", "done", 64'(bus.done), 64'd0);
    check("clear", "err",  64'(bus.err),  64'd0);
    check("clear", "z", {bus.zhi, bus.zlo}, 64'd0);
    #1 clear = 1'b0;
    repeat (40) @(negedge clock);
    #1;
    check("clear", "no_done", 64'(n_done), 64'(n_issued));
    run("rol", OP_ROL, 32'h80000001, 32'd0, 32'h00000003, 32'h00000000, 1'b0, 1);

    // start while a divide is busy must be ignored.
    issue("div_busy", OP_DIV, 32'd1000, 32'hFFFFFFF9, 32'hFFFFFF72, 32'h00000006, 1'b0, 33);
    repeat (4) @(negedge clock);
    bus.start = 1'b1; bus.op = OP_ADD; bus.a_in = 32'd5; bus.y_in = 32'd1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done("div_busy");
    repeat (5) @(negedge clock);
    #1;
    check("div_busy", "single_done", 64'(n_done), 64'(n_issued));
    check("end", "scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller wrapped around the shared 32-bit ALU operation set.
- Accepts one operation per start pulse and captures both operands.
- Single-cycle ops complete in one cycle; multiply uses iterative radix-2 Booth and divide uses signed restoring division.
- Writes the 64-bit result into the Z pair (zlo/zhi) and reports completion with a busy/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand width; Z pair is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  5  operation code; encodings in Behaviour.
- a_in  in  WIDTH  operand A (bus value).
- y_in  in  WIDTH  operand Y (Y register value).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: divide-by-zero or illegal op.
- zlo  out  WIDTH  result low word / quotient.
- zhi  out  WIDTH  result high word / remainder.

Behaviour:
- Reset: clock-independent, forces the following regardless of state:
  - state = IDLE.
  - busy, done, err = 0.
  - zlo, zhi = 0.
  - counter, operand and partial-product registers = 0.
- Op codes and results (Y is the left operand):
  - 00011 add: Y+A.
  - 00100 sub: Y-A.
  - 00101 shr: Y logical right by 1.
  - 00110 shl: Y left by 1.
  - 00111 ror: Y rotate right by 1.
  - 01000 rol: Y rotate left by 1.
  - 01001 and: Y&A.
  - 01010 or: Y|A.
  - 01110 mul: signed Y*A.
  - 01111 div: signed Y/A.
  - 10000 neg: -A.
  - 10001 not: ~A.
  - All other codes are illegal.
- Width rules:
  - Add/sub/neg wrap modulo 2^32.
  - Single-cycle ops: zhi = 32 copies of zlo[31].
- States: IDLE, EXEC, MUL, DIV, FIX, DONE.
- Acceptance (edge E0): IDLE with start=1 captures op, a_in and y_in; the captured op selects the next state:
  - mul -> MUL.
  - div with a_in != 0 -> DIV.
  - everything else, including div-by-zero and illegal op -> EXEC.
- start while busy: ignored, never queued.
- Operand stability: after E0, input changes have no effect on the operation in flight.
- EXEC (one edge, E1): write Z, go to DONE.
  - Divide-by-zero: zlo = 0xFFFFFFFF, zhi = dividend Y, err=1.
  - Illegal op: zlo = zhi = 0, err=1.
- MUL:
  - Booth radix-2 over the 65-bit {P_hi, P_lo, q-1} register.
  - Each edge inspects {P_lo[0], q-1}: 01 -> add multiplicand, 10 -> subtract multiplicand, else no add/subtract; then arithmetic right shift by 1.
  - 32 iterations on E1..E32; at E32 write {zhi, zlo} = 64-bit product and go to DONE.
- DIV:
  - Magnitudes of Y and A are taken at entry.
  - Unsigned restoring division: 32 iterations on E1..E32.
  - FIX at E33 applies signs, writes Z and goes to DONE:
    - Quotient sign = sign(Y) xor sign(A).
    - Remainder takes the sign of Y.
    - zlo = quotient, zhi = remainder.
  - -2^31 / -1 gives quotient 0x80000000, remainder 0, err=0 (natural wrap).
- DONE:
  - done=1 for exactly one cycle; err holds the operation's flag.
  - Next edge returns to IDLE; done and err drop.
  - A start seen in DONE is ignored.
- Latency (done high following edge): single-cycle op E1, mul E32, div E33.
- Z hold: zlo/zhi change only on the result-write edge and otherwise hold the last result.
- Busy: high from the cycle after E0 through the DONE cycle.
- clear mid-operation: aborts immediately to reset values; no done pulse is produced.

Decomposition:
- Package alu_pkg holds:
  - The op code localparams (OP_ADD..OP_NOT).
  - The state enum encoding.
  - WIDTH default.
  - Div-by-zero result constant 0xFFFFFFFF.
- One sub-module, alu_muldiv_iter, is natural. It contains:
  - The iterative Booth/restoring datapath and the iteration counter.
  - Sign fixup logic.
  - Ports: load, is_div, step, fix, operands in, {hi, lo} out, last_iter flag.
- The FSM, handshake and single-cycle op logic stay in alu_sequencer.

Test Plan:
- add, Y=5, A=7 -> at E1 done=1, zlo=0x0000000C, zhi=0, err=0; busy low the cycle after done.
- mul, Y=-3, A=7 -> done one cycle after E32, zhi=0xFFFFFFFF, zlo=0xFFFFFFEB.
- mul, Y=A=0x80000000 -> zhi=0x40000000, zlo=0.
- div, Y=-7, A=2 -> done one cycle after E33, zlo=0xFFFFFFFD, zhi=0xFFFFFFFF.
- div, Y=100, A=0 -> done at E1, err=1, zlo=0xFFFFFFFF, zhi=0x00000064.
- Start mul, pulse clear at iteration 10 -> all outputs 0 immediately, no done. Then rol with Y=0x80000001 -> zlo=0x00000003, zhi=0.
- While a div is busy: pulse start with op=add and change a_in -> the div result is unaffected and only one done is produced.
